// File: rtl/adder16_stream_tester_pkg.sv
// adder16_tester_pkg: shared types and constants for the adder16 stream tester.
// Optional corner vectors are enabled with ADDER16_TESTER_CORNER_EN (see top).
package adder16_tester_pkg;

    // Tester sequencing states, exposed on the top-level debug port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Right-shifting Galois feedback mask for x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One expected-result entry travelling alongside the adder pipeline.
    typedef struct packed {
        logic        valid;
        logic [16:0] exp;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] idx;
    } exp_entry_t;

    // Fixed corner vectors issued ahead of the LFSR stream when enabled.
    localparam int          NUM_CORNERS = 4;
    localparam logic [15:0] CORNER0_A = 16'h0000, CORNER0_B = 16'h0000;
    localparam logic [15:0] CORNER1_A = 16'hFFFF, CORNER1_B = 16'h0001;
    localparam logic [15:0] CORNER2_A = 16'hFFFF, CORNER2_B = 16'hFFFF;
    localparam logic [15:0] CORNER3_A = 16'h8000, CORNER3_B = 16'h8000;

    // One Galois LFSR step.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    function automatic logic [15:0] corner_a(input logic [1:0] i);
        case (i)
            2'd0:    return CORNER0_A;
            2'd1:    return CORNER1_A;
            2'd2:    return CORNER2_A;
            default: return CORNER3_A;
        endcase
    endfunction

    function automatic logic [15:0] corner_b(input logic [1:0] i);
        case (i)
            2'd0:    return CORNER0_B;
            2'd1:    return CORNER1_B;
            2'd2:    return CORNER2_B;
            default: return CORNER3_B;
        endcase
    endfunction

endpackage

// File: rtl/adder16_stream_tester_if.sv
// Operand/result bus between the stream tester (master) and the registered
// 16-bit adder wrapper (slave). No handshake: enable qualifies A/B each cycle,
// and Sum/Cout carry the result of the operands presented a fixed number of
// cycles earlier.
interface adder16_stream_tester_if;
    logic [15:0] A;
    logic [15:0] B;
    logic        enable;
    logic [15:0] Sum;
    logic        Cout;

    modport master (output A, output B, output enable, input Sum, input Cout);
    modport slave  (input A, input B, input enable, output Sum, output Cout);
endinterface

// File: rtl/adder16_lfsr.sv
// adder16_lfsr: 16-bit Galois LFSR with seed load and advance enable.
// value_o shows the value to use this cycle: the seed while loading,
// otherwise the stored state. Advancing steps from that value.
module adder16_lfsr
    import adder16_tester_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        adv_i,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign value_o = load_i ? SEED : lfsr_q;

    // Next state: step from the current (possibly freshly loaded) value.
    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i) begin
            lfsr_d = lfsr_step(value_o);
        end else if (load_i) begin
            lfsr_d = SEED;
        end
    end

    // State register, reset to the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/adder16_stream_tester.sv
// adder16_stream_tester: drives a deterministic operand stream into the
// registered adder wrapper and checks Sum/Cout against a delayed golden sum.
// Define ADDER16_TESTER_CORNER_EN to issue four fixed corner vectors before
// the LFSR stream (NUM_VECTORS must then be >= 4).
module adder16_stream_tester
    import adder16_tester_pkg::*;
#(
    parameter int          NUM_VECTORS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [15:0] SEED_A      = 16'hACE1,
    parameter logic [15:0] SEED_B      = 16'h1D2B
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    adder16_stream_tester_if.master         adder_if,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [15:0]                     err_count,
    output logic [15:0]                     fail_A,
    output logic [15:0]                     fail_B,
    output logic [15:0]                     fail_idx,
    output state_e                          state_o
);

    localparam int          DW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LATENCY - 1);
    localparam logic [15:0] VEC_LAST  = 16'(NUM_VECTORS);

    state_e        state_q, state_d;
    logic [15:0]   vec_cnt_q, vec_cnt_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          issue;
    logic          run_start;
    logic [15:0]   issue_idx;
    logic [15:0]   issue_a, issue_b;
    logic          lfsr_adv;
    logic [15:0]   lfsr_a_val, lfsr_b_val;

    logic [15:0]   a_q, b_q, idx_q;
    logic          enable_q;
    logic          busy_q, done_q, pass_q;
    logic [15:0]   err_q, err_d;
    logic [15:0]   fail_a_q, fail_a_d, fail_b_q, fail_b_d, fail_idx_q, fail_idx_d;

    exp_entry_t    pipe_q [LATENCY];
    exp_entry_t    push_entry;
    exp_entry_t    tail;
    logic          mismatch;

    // Sequencing: issue NUM_VECTORS vectors, then wait LATENCY cycles for the
    // last result before reporting.
    always_comb begin
        state_d     = state_q;
        vec_cnt_d   = vec_cnt_q;
        drain_cnt_d = drain_cnt_q;
        issue       = 1'b0;
        run_start   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    run_start = 1'b1;
                    issue     = 1'b1;
                    vec_cnt_d = 16'd1;
                end
            end
            RUN: begin
                if (vec_cnt_q == VEC_LAST) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    issue     = 1'b1;
                    vec_cnt_d = vec_cnt_q + 16'd1;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue_idx = run_start ? 16'd0 : vec_cnt_q;

`ifdef ADDER16_TESTER_CORNER_EN
    logic corner_sel;

    // Corner vectors replace the first few issues; the LFSRs hold meanwhile.
    always_comb begin
        corner_sel = issue && (issue_idx < 16'(NUM_CORNERS));
        lfsr_adv   = issue && !corner_sel;
        issue_a    = corner_sel ? corner_a(issue_idx[1:0]) : lfsr_a_val;
        issue_b    = corner_sel ? corner_b(issue_idx[1:0]) : lfsr_b_val;
    end
`else
    // Every vector comes straight from the LFSRs.
    always_comb begin
        lfsr_adv = issue;
        issue_a  = lfsr_a_val;
        issue_b  = lfsr_b_val;
    end
`endif

    adder16_lfsr #(.SEED(SEED_A)) u_lfsr_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (run_start),
        .adv_i   (lfsr_adv),
        .value_o (lfsr_a_val)
    );

    adder16_lfsr #(.SEED(SEED_B)) u_lfsr_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (run_start),
        .adv_i   (lfsr_adv),
        .value_o (lfsr_b_val)
    );

    // The operand registers act as the stage ahead of the expected pipeline,
    // so a depth of LATENCY lines the tail up with Sum/Cout.
    always_comb begin
        push_entry       = '0;
        push_entry.valid = enable_q;
        push_entry.exp   = {1'b0, a_q} + {1'b0, b_q};
        push_entry.a     = a_q;
        push_entry.b     = b_q;
        push_entry.idx   = idx_q;
    end

    assign tail     = pipe_q[LATENCY-1];
    assign mismatch = tail.valid && ({adder_if.Cout, adder_if.Sum} != tail.exp);

    // Error accounting: clear on run start, saturate the count, latch the
    // first failing vector only.
    always_comb begin
        err_d      = err_q;
        fail_a_d   = fail_a_q;
        fail_b_d   = fail_b_q;
        fail_idx_d = fail_idx_q;
        if (run_start) begin
            err_d      = '0;
            fail_a_d   = '0;
            fail_b_d   = '0;
            fail_idx_d = '0;
        end else if (mismatch) begin
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
            if (err_q == 16'd0) begin
                fail_a_d   = tail.a;
                fail_b_d   = tail.b;
                fail_idx_d = tail.idx;
            end
        end
    end

    // FSM state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_cnt_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_cnt_q   <= vec_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Registered operand bus; A/B hold their last value when not issuing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            enable_q <= 1'b0;
        end else begin
            enable_q <= issue;
            if (issue) begin
                a_q   <= issue_a;
                b_q   <= issue_b;
                idx_q <= issue_idx;
            end
        end
    end

    // Expected-result shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= push_entry;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_idx_q <= '0;
        end else begin
            busy_q     <= (state_d == RUN) || (state_d == DRAIN);
            done_q     <= (state_d == DONE);
            pass_q     <= (state_d == DONE) && (err_d == 16'd0);
            err_q      <= err_d;
            fail_a_q   <= fail_a_d;
            fail_b_q   <= fail_b_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    assign adder_if.A      = a_q;
    assign adder_if.B      = b_q;
    assign adder_if.enable = enable_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign fail_A          = fail_a_q;
    assign fail_B          = fail_b_q;
    assign fail_idx        = fail_idx_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_adder16_stream_tester.sv
// Bench for adder16_stream_tester with a two-register adder model that can
// corrupt Sum[0] from vector 5 onward. Build with ADDER16_TESTER_CORNER_EN
// defined to exercise the corner-vector variant.
module tb_adder16_stream_tester;
    import adder16_tester_pkg::*;

    localparam int NV  = 16;
    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy, done, pass;
    logic [15:0] err_count, fail_A, fail_B, fail_idx;
    state_e      dbg_state;

    adder16_stream_tester_if ad_if ();

    adder16_stream_tester #(
        .NUM_VECTORS (NV),
        .LATENCY     (LAT),
        .SEED_A      (16'hACE1),
        .SEED_B      (16'h1D2B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .adder_if  (ad_if),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_A    (fail_A),
        .fail_B    (fail_B),
        .fail_idx  (fail_idx),
        .state_o   (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder wrapper model: operand register then result register.
    logic [15:0] a1, b1;
    logic        en1;
    logic [16:0] res;
    int          res_cnt;
    bit          fault_on;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1      <= '0;
            b1      <= '0;
            en1     <= 1'b0;
            res     <= '0;
            res_cnt <= 0;
        end else begin
            a1  <= ad_if.A;
            b1  <= ad_if.B;
            en1 <= ad_if.enable;
            if (en1) res <= ({1'b0, a1} + {1'b0, b1}) ^ ((fault_on && res_cnt >= 5) ? 17'd1 : 17'd0);
            if (!busy) res_cnt <= 0;
            else if (en1) res_cnt <= res_cnt + 1;
        end
    end

    assign ad_if.Sum  = res[15:0];
    assign ad_if.Cout = res[16];

    // Expected vector stream
    logic [15:0] exp_a [NV];
    logic [15:0] exp_b [NV];
    logic [15:0] obs_a [NV];
    logic [15:0] obs_b [NV];

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    task automatic build_expected();
        logic [15:0] la, lb;
        la = 16'hACE1;
        lb = 16'h1D2B;
        for (int i = 0; i < NV; i++) begin
`ifdef ADDER16_TESTER_CORNER_EN
            if (i < 4) begin
                case (i)
                    0: begin exp_a[i] = 16'h0000; exp_b[i] = 16'h0000; end
                    1: begin exp_a[i] = 16'hFFFF; exp_b[i] = 16'h0001; end
                    2: begin exp_a[i] = 16'hFFFF; exp_b[i] = 16'hFFFF; end
                    default: begin exp_a[i] = 16'h8000; exp_b[i] = 16'h8000; end
                endcase
                continue;
            end
`endif
            exp_a[i] = la;
            exp_b[i] = lb;
            la = ref_step(la);
            lb = ref_step(lb);
        end
    endtask

    // Scoreboard counters and checker
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_A"}, ad_if.A, 0);
        chk({tag, "_B"}, ad_if.B, 0);
        chk({tag, "_enable"}, ad_if.enable, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_fail_A"}, fail_A, 0);
        chk({tag, "_fail_B"}, fail_B, 0);
        chk({tag, "_fail_idx"}, fail_idx, 0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // Driver: one full run, optionally pulsing start mid-run at busy cycles 3 and 10.
    task automatic do_run(input bit pulse_mid, output int bcnt, output int vcnt, output logic [15:0] e0);
        int guard;
        bcnt  = 0;
        vcnt  = 0;
        guard = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = err_count;
        while (busy && guard < 5000) begin
            if (ad_if.enable) begin
                if (vcnt < NV) begin
                    obs_a[vcnt] = ad_if.A;
                    obs_b[vcnt] = ad_if.B;
                end
                vcnt++;
            end
            bcnt++;
            start = pulse_mid && (bcnt == 3 || bcnt == 10);
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        chk("done_after_run", done, 1);
    endtask

    task automatic chk_stream(input string tag);
        for (int i = 0; i < NV; i++) begin
            chk({tag, "_A"}, obs_a[i], exp_a[i]);
            chk({tag, "_B"}, obs_b[i], exp_b[i]);
        end
    endtask

    // Directed sequence
    initial begin
        int          bc, vc, en_cnt;
        logic [15:0] e0;
        rst_n    = 1'b0;
        start    = 1'b0;
        fault_on = 1'b0;
        build_expected();

        // Reset values
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");

        // Idle: no start, no enable for 100 cycles
        rst_n  = 1'b1;
        en_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (ad_if.enable) en_cnt++;
        end
        chk("idle_enable_cycles", en_cnt, 0);
        chk("idle_state", 32'(dbg_state), 32'(IDLE));

        // Golden run
        do_run(1'b0, bc, vc, e0);
        chk("golden_busy_cycles", bc, NV + LAT);
        chk("golden_vec_count", vc, NV);
        chk("golden_err_count", err_count, 0);
        chk("golden_pass", pass, 1);
        chk("golden_state", 32'(dbg_state), 32'(DONE));
        chk_stream("golden_vec");
`ifdef ADDER16_TESTER_CORNER_EN
        chk("corner_vec2_A", obs_a[2], 16'hFFFF);
        chk("corner_vec2_B", obs_b[2], 16'hFFFF);
        chk("corner_vec4_A", obs_a[4], 16'hACE1);
        chk("corner_vec4_B", obs_b[4], 16'h1D2B);
`else
        chk("vec0_A", obs_a[0], 16'hACE1);
        chk("vec0_B", obs_b[0], 16'h1D2B);
        chk("vec1_A", obs_a[1], 16'hE270);
        chk("vec1_B", obs_b[1], 16'hBA95);
`endif

        // Faulty adder from vector 5, with start pulses ignored mid-run
        fault_on = 1'b1;
        do_run(1'b1, bc, vc, e0);
        chk("fault_busy_cycles", bc, NV + LAT);
        chk("fault_vec_count", vc, NV);
        chk("fault_err_count", err_count, NV - 5);
        chk("fault_fail_idx", fail_idx, 5);
        chk("fault_fail_A", fail_A, exp_a[5]);
        chk("fault_fail_B", fail_B, exp_b[5]);
        chk("fault_pass", pass, 0);

        // Restart from DONE clears the error state
        fault_on = 1'b0;
        do_run(1'b0, bc, vc, e0);
        chk("restart_err_cleared", e0, 0);
        chk("restart_err_count", err_count, 0);
        chk("restart_fail_idx", fail_idx, 0);
        chk("restart_pass", pass, 1);

        // Reset in the middle of a run
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrun_busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_run(1'b0, bc, vc, e0);
        chk("post_reset_busy_cycles", bc, NV + LAT);
        chk("post_reset_pass", pass, 1);
        chk_stream("post_reset_vec");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adder16_stream_tester.md
# adder16_stream_tester

Self-checking stimulus/response engine for the registered 16-bit adder wrapper. It drives the wrapper's operand side (A, B, enable) with a deterministic vector stream and checks the wrapper's result side (Sum, Cout) against a golden 17-bit sum, delayed to match the wrapper's two-register latency. It sits beside the adder on the lab test harness and reports pass/fail plus the first failing vector for silicon/FPGA bring-up.

## Interface
- NUM_VECTORS, 1024: vectors issued per run; legal range 1..65535.
- LATENCY, 2: cycles from operands driven to result valid at Sum/Cout; legal range ≥1.
- SEED_A, 16'hACE1: LFSR seed for A; must be nonzero.
- SEED_B, 16'h1D2B: LFSR seed for B; must be nonzero.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- A  out  16  operand A to adder.
- B  out  16  operand B to adder.
- enable  out  1  result-capture enable to adder.
- Sum  in  16  adder result.
- Cout  in  1  adder carry-out.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE, held until next start.
- pass  out  1  done && err_count==0.
- err_count  out  16  mismatches this run, saturates at 16'hFFFF.
- fail_A, fail_B  out  16 each  operands of first mismatching vector.
- fail_idx  out  16  index (0-based) of first mismatch.

## Operation
- FSM states: IDLE → RUN on start; RUN → DRAIN after NUM_VECTORS issue cycles; DRAIN → DONE after LATENCY cycles; DONE → RUN on start.
- Reset: state IDLE; A=0, B=0, enable=0, busy=0, done=0, pass=0, err_count=0, fail_A=0, fail_B=0, fail_idx=0; LFSRs loaded with seeds; compare pipeline valid bits cleared.
- Entering RUN: LFSRs reload seeds, vector counter, err_count, fail_* cleared.
- RUN: each cycle drive A, B from the LFSRs with enable=1, advance both LFSRs (Galois, taps x^16+x^14+x^13+x^11+1), increment vector counter, push {valid=1, A+B as 17 bits, A, B, idx} into the expected pipeline.
- DRAIN/IDLE/DONE: enable=0, A/B hold last value, pipeline pushes valid=0.
- Compare: when pipeline tail valid, {Cout,Sum} != expected → err_count += 1 (saturating); if first mismatch of run, capture fail_A, fail_B, fail_idx.
- Arithmetic: expected = {1'b0,A}+{1'b0,B}, bit 16 compared against Cout.
- start while busy: ignored. start held high in DONE: new run starts each time DONE is reached.
- rst_n low mid-run: immediate return to reset values; no partial result reported.

## Timing
- start high at edge k (IDLE) → enable=1 with vector 0 from cycle k+1.
- Vector i driven in cycle k+1+i; compared in cycle k+1+i+LATENCY.
- busy high cycles k+1 .. k+NUM_VECTORS+LATENCY; done rises at edge k+NUM_VECTORS+LATENCY+1.
- err_count/fail_* update at the edge after the compare cycle; final before done rises.
- Outputs are all registered; no combinational path from Sum/Cout to any output.

## Configuration
- ADDER16_TESTER_CORNER_EN defined: vectors 0–3 are fixed corners (0000+0000, FFFF+0001, FFFF+FFFF, 8000+8000); LFSR stream starts at vector 4 and LFSRs do not advance during corners; NUM_VECTORS must be ≥4.
- Undefined: all vectors from LFSRs; no corner logic synthesized.

## Structure
- Shared package adder16_tester_pkg: state enum (IDLE, RUN, DRAIN, DONE), LFSR tap constant, expected-entry struct {valid, exp[16:0], a, b, idx}, corner vector constants.
- One sub-module: adder16_lfsr (16-bit Galois LFSR, seed load, advance enable), instantiated twice.
- Expected pipeline is an in-block shift register of depth LATENCY.

## Test plan
- Reset: rst_n low → all outputs zero, state IDLE; release, no start → enable stays 0 for 100 cycles.
- Golden DUT, NUM_VECTORS=16, LATENCY=2: start pulse → busy 18 cycles, done high, err_count=0, pass=1; vector 0 A=16'hACE1, B=16'h1D2B.
- Faulty DUT (Sum[0] inverted from vector 5 on): err_count=11, fail_idx=5, fail_A/fail_B equal vector 5 operands, pass=0.
- start asserted at cycles 3 and 10 of a run → ignored, run length unchanged; start in DONE → new run, err_count cleared.
- rst_n low at cycle 8 of RUN → outputs return to reset values same cycle; new start gives identical vector sequence.
- ADDER16_TESTER_CORNER_EN: vector 2 drives FFFF+FFFF, expected Cout=1 Sum=FFFE; vector 4 equals SEED_A/SEED_B.
